// File: rtl/mixed_precision_sequencer_pkg.sv
// Shared types and helpers for the mixed-precision dot-product sequencer.
//   - NBITS_MIXED_CYCLES / NBITS_MAX_KER : slice-index and kernel-step widths
//   - ivec_mode_fmt                      : vector/mixed operand format encoding
//   - mps_state_e                        : sequencer FSM states
//   - mixed_slices()                     : slice count R for a given format
package mixed_precision_sequencer_pkg;

    localparam int NBITS_MIXED_CYCLES = 3;
    localparam int NBITS_MAX_KER      = 4;

    typedef enum logic [3:0] {
        IVEC_FMT_16    = 4'd0,
        IVEC_FMT_8     = 4'd1,
        IVEC_FMT_4     = 4'd2,
        IVEC_FMT_2     = 4'd3,
        IVEC_FMT_2X4   = 4'd4,
        IVEC_FMT_4X8   = 4'd5,
        IVEC_FMT_8X16  = 4'd6,
        IVEC_FMT_2X8   = 4'd7,
        IVEC_FMT_4X16  = 4'd8,
        IVEC_FMT_2X16  = 4'd9
    } ivec_mode_fmt;

    typedef enum logic [0:0] {
        MPS_IDLE  = 1'b0,
        MPS_ISSUE = 1'b1
    } mps_state_e;

    // Number of slices the narrow operand must be split into; 8 needs 4 bits.
    function automatic logic [3:0] mixed_slices(input ivec_mode_fmt fmt);
        logic [3:0] r;
        case (fmt)
            IVEC_FMT_2X4, IVEC_FMT_4X8, IVEC_FMT_8X16: r = 4'd2;
            IVEC_FMT_2X8, IVEC_FMT_4X16:               r = 4'd4;
            IVEC_FMT_2X16:                             r = 4'd8;
            default:                                   r = 4'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mixed_precision_sequencer_nested_counter.sv
// mps_nested_counter: two-level slice/kernel counter, kernel index innermost.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of both indices (wins over step)
//   step       : advance one sub-op
//   r_m1, k_m1 : slice count minus one, kernel steps minus one
//   slice/kidx : current indices
//   wrap_k     : kernel index is at its final value for this slice
//   last       : current position is the final sub-op of the request
module mps_nested_counter
    import mixed_precision_sequencer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          step,
    input  logic [NBITS_MIXED_CYCLES-1:0] r_m1,
    input  logic [NBITS_MAX_KER-1:0]      k_m1,
    output logic [NBITS_MIXED_CYCLES-1:0] slice,
    output logic [NBITS_MAX_KER-1:0]      kidx,
    output logic                          wrap_k,
    output logic                          last
);

    logic [NBITS_MIXED_CYCLES-1:0] slice_r;
    logic [NBITS_MAX_KER-1:0]      kidx_r;

    assign wrap_k = (kidx_r == k_m1);
    assign last   = wrap_k && (slice_r == r_m1);
    assign slice  = slice_r;
    assign kidx   = kidx_r;

    // Slice-major / kernel-minor position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_r <= {NBITS_MIXED_CYCLES{1'b0}};
            kidx_r  <= {NBITS_MAX_KER{1'b0}};
        end else if (clr) begin
            slice_r <= {NBITS_MIXED_CYCLES{1'b0}};
            kidx_r  <= {NBITS_MAX_KER{1'b0}};
        end else if (step) begin
            if (wrap_k) begin
                kidx_r  <= {NBITS_MAX_KER{1'b0}};
                slice_r <= slice_r + {{(NBITS_MIXED_CYCLES-1){1'b0}}, 1'b1};
            end else begin
                kidx_r  <= kidx_r + {{(NBITS_MAX_KER-1){1'b0}}, 1'b1};
                slice_r <= slice_r;
            end
        end else begin
            slice_r <= slice_r;
            kidx_r  <= kidx_r;
        end
    end

endmodule

// File: rtl/mixed_precision_sequencer.sv
// mixed_precision_sequencer: expands one accepted mixed-precision dotp request
// into R*K slice/kernel sub-ops issued over valid/ready to the datapath.
//   clk, rst_n, setback_i              : clock, async reset, sync abort (top priority)
//   req_valid_i/req_ready_o            : request handshake (fmt, skip = K)
//   issue_valid_o/issue_ready_i        : sub-op handshake
//   issue_slice_o/kidx_o/first_o/last_o: sub-op position
//   busy_o, done_o                     : ISSUE state, completion pulse
//   csr_we_o, csr_cycle_o              : mixed-cycle CSR update on slice wrap
module mixed_precision_sequencer
    import mixed_precision_sequencer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          setback_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  ivec_mode_fmt                  req_fmt_i,
    input  logic [NBITS_MAX_KER-1:0]      req_skip_i,
    output logic                          issue_valid_o,
    input  logic                          issue_ready_i,
    output logic [NBITS_MIXED_CYCLES-1:0] issue_slice_o,
    output logic [NBITS_MAX_KER-1:0]      issue_kidx_o,
    output logic                          issue_first_o,
    output logic                          issue_last_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          csr_we_o,
    output logic [NBITS_MIXED_CYCLES-1:0] csr_cycle_o
);

    mps_state_e                    state_r;
    logic [NBITS_MIXED_CYCLES-1:0] r_m1_r;
    logic [NBITS_MAX_KER-1:0]      k_m1_r;
    logic                          done_r;

    logic                          accept_s;
    logic                          hs_s;
    logic                          cnt_clr_s;
    logic [3:0]                    slices_s;
    logic [3:0]                    slices_m1_s;
    logic [NBITS_MIXED_CYCLES-1:0] slice_s;
    logic [NBITS_MAX_KER-1:0]      kidx_s;
    logic                          wrap_k_s;
    logic                          last_s;

    mps_nested_counter u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr_s),
        .step   (hs_s),
        .r_m1   (r_m1_r),
        .k_m1   (k_m1_r),
        .slice  (slice_s),
        .kidx   (kidx_s),
        .wrap_k (wrap_k_s),
        .last   (last_s)
    );

    // Handshake qualification; setback blocks both handshakes that cycle.
    always_comb begin
        req_ready_o   = (state_r == MPS_IDLE)  && !setback_i;
        issue_valid_o = (state_r == MPS_ISSUE) && !setback_i;
        accept_s      = req_valid_i && req_ready_o;
        hs_s          = issue_valid_o && issue_ready_i;
        cnt_clr_s     = setback_i || accept_s || (hs_s && last_s);
        slices_s      = mixed_slices(req_fmt_i);
        slices_m1_s   = slices_s - 4'd1;
    end

    // Position, CSR and status outputs derived from registered state.
    always_comb begin
        issue_slice_o = slice_s;
        issue_kidx_o  = kidx_s;
        issue_first_o = (slice_s == {NBITS_MIXED_CYCLES{1'b0}}) && (kidx_s == {NBITS_MAX_KER{1'b0}});
        issue_last_o  = (state_r == MPS_ISSUE) && last_s;
        busy_o        = (state_r == MPS_ISSUE);
        done_o        = done_r;
        csr_we_o      = hs_s && wrap_k_s;
        if (slice_s == r_m1_r) begin
            csr_cycle_o = {NBITS_MIXED_CYCLES{1'b0}};
        end else begin
            csr_cycle_o = slice_s + {{(NBITS_MIXED_CYCLES-1){1'b0}}, 1'b1};
        end
    end

    // Sequencer FSM: latches R-1 / K-1 on accept, returns to IDLE on the
    // final handshake or on setback. Latched limits drop back to a single
    // sub-op whenever idle so IDLE outputs match the reset view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MPS_IDLE;
            r_m1_r  <= {NBITS_MIXED_CYCLES{1'b0}};
            k_m1_r  <= {NBITS_MAX_KER{1'b0}};
            done_r  <= 1'b0;
        end else if (setback_i) begin
            state_r <= MPS_IDLE;
            r_m1_r  <= {NBITS_MIXED_CYCLES{1'b0}};
            k_m1_r  <= {NBITS_MAX_KER{1'b0}};
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                MPS_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= MPS_ISSUE;
                        r_m1_r  <= slices_m1_s[NBITS_MIXED_CYCLES-1:0];
                        // K = 0 behaves as a single kernel step
                        if (req_skip_i == {NBITS_MAX_KER{1'b0}}) begin
                            k_m1_r <= {NBITS_MAX_KER{1'b0}};
                        end else begin
                            k_m1_r <= req_skip_i - {{(NBITS_MAX_KER-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_r <= MPS_IDLE;
                    end
                end
                MPS_ISSUE: begin
                    done_r <= hs_s && last_s;
                    if (hs_s && last_s) begin
                        state_r <= MPS_IDLE;
                        r_m1_r  <= {NBITS_MIXED_CYCLES{1'b0}};
                        k_m1_r  <= {NBITS_MAX_KER{1'b0}};
                    end else begin
                        state_r <= MPS_ISSUE;
                    end
                end
                default: begin
                    state_r <= MPS_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixed_precision_sequencer.sv
// Scoreboard bench for mixed_precision_sequencer: the request driver pushes
// expected sub-ops and completion cycles; a negedge monitor pops and checks.
module tb_mixed_precision_sequencer;
    import mixed_precision_sequencer_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         setback;
    logic         req_valid;
    logic         req_ready;
    ivec_mode_fmt req_fmt;
    logic [3:0]   req_skip;
    logic         issue_valid;
    logic         issue_ready;
    logic [2:0]   issue_slice;
    logic [3:0]   issue_kidx;
    logic         issue_first;
    logic         issue_last;
    logic         busy;
    logic         done;
    logic         csr_we;
    logic [2:0]   csr_cycle;

    mixed_precision_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .setback_i     (setback),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_fmt_i     (req_fmt),
        .req_skip_i    (req_skip),
        .issue_valid_o (issue_valid),
        .issue_ready_i (issue_ready),
        .issue_slice_o (issue_slice),
        .issue_kidx_o  (issue_kidx),
        .issue_first_o (issue_first),
        .issue_last_o  (issue_last),
        .busy_o        (busy),
        .done_o        (done),
        .csr_we_o      (csr_we),
        .csr_cycle_o   (csr_cycle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] s;
        logic [3:0] k;
        logic       f;
        logic       l;
        logic       we;
        logic [2:0] cc;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t mon_e;
    int   cyc        = 0;
    int   checks     = 0;
    int   errors     = 0;
    int   stall_from = -100;
    int   sb_cycle   = -100;

    always @(posedge clk) cyc <= cyc + 1;

    // ready / setback schedule, applied just after each rising edge
    always @(posedge clk) begin
        #1;
        issue_ready = !(cyc >= stall_from && cyc < stall_from + 3);
        setback     = (cyc == sb_cycle);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: sub-op handshakes, stall hold, completion timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue @cycle %0d: slice %0d kidx %0d", cyc, issue_slice, issue_kidx);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue{slice,kidx,first,last,we,cyc}",
                        {19'd0, issue_slice, issue_kidx, issue_first, issue_last, csr_we, csr_cycle},
                        {19'd0, mon_e.s, mon_e.k, mon_e.f, mon_e.l, mon_e.we, mon_e.cc});
                end
            end else begin
                chk("csr_we_without_handshake", {31'd0, csr_we}, 32'd0);
                if (issue_valid && exp_q.size() > 0) begin
                    chk("stall_hold{slice,kidx,first,last}",
                        {25'd0, issue_slice, issue_kidx, issue_first, issue_last},
                        {25'd0, exp_q[0].s, exp_q[0].k, exp_q[0].f, exp_q[0].l});
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done @cycle %0d: got 1 expected 0", cyc);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    // Offer one request; on accept push n_push expected sub-ops of an R x K
    // walk, and (optionally) the done cycle = accept + R*K + 1 + stall cycles.
    task automatic send(input ivec_mode_fmt f, input logic [3:0] sk, input int r, input int k,
                        input int n_push, input bit exp_done, input int extra, output int acc);
        exp_t e;
        int   cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_fmt = f; req_skip = sk;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                cnt = 0;
                for (int s = 0; s < r; s++) begin
                    for (int kk = 0; kk < k; kk++) begin
                        if (cnt < n_push) begin
                            e.s  = 3'(s);
                            e.k  = 4'(kk);
                            e.f  = (s == 0 && kk == 0);
                            e.l  = (s == r - 1 && kk == k - 1);
                            e.we = (kk == k - 1);
                            e.cc = (s == r - 1) ? 3'd0 : 3'(s + 1);
                            exp_q.push_back(e);
                        end
                        cnt++;
                    end
                end
                if (exp_done) done_q.push_back(cyc + r * k + 1 + extra);
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_cycle(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cyc >= n) break;
        end
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && done_q.size() == 0) break;
        end
        chk({name, "_pending_issues"}, exp_q.size(), 32'd0);
        chk({name, "_pending_done"}, done_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc;
        int acc2;
        int sbc;
        rst_n = 1'b0; setback = 1'b0; req_valid = 1'b0; issue_ready = 1'b1;
        req_fmt = IVEC_FMT_16; req_skip = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready",   {31'd0, req_ready},   32'd1);
        chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_busy",        {31'd0, busy},        32'd0);
        chk("rst_done",        {31'd0, done},        32'd0);
        chk("rst_csr_we",      {31'd0, csr_we},      32'd0);
        chk("rst_slice",       {29'd0, issue_slice}, 32'd0);
        chk("rst_kidx",        {28'd0, issue_kidx},  32'd0);
        chk("rst_csr_cycle",   {29'd0, csr_cycle},   32'd0);
        chk("rst_first",       {31'd0, issue_first}, 32'd1);
        chk("rst_last",        {31'd0, issue_last},  32'd0);

        // 4x8, K=3: R=2, six sub-ops, done at accept+7
        send(IVEC_FMT_4X8, 4'd3, 2, 3, 6, 1'b1, 0, acc);
        @(negedge clk);
        chk("t1_busy",      {31'd0, busy},      32'd1);
        chk("t1_req_ready", {31'd0, req_ready}, 32'd0);
        drain("t1");

        // 2x16, K=0 (acts as 1): R=8, slices 0..7
        send(IVEC_FMT_2X16, 4'd0, 8, 1, 8, 1'b1, 0, acc);
        drain("t2");

        // 2x8, K=2, ready low on issue cycles 2..4: done three cycles late
        send(IVEC_FMT_2X8, 4'd2, 4, 2, 8, 1'b1, 3, acc);
        stall_from = acc + 2;
        wait_cycle(acc + 3);
        chk("t3_valid_in_stall", {31'd0, issue_valid}, 32'd1);
        drain("t3");
        stall_from = -100;

        // non-mixed format, K=1: single sub-op, first = last = 1
        send(IVEC_FMT_8, 4'd1, 1, 1, 1, 1'b1, 0, acc);
        drain("t4");

        // 4x16, K=2, setback on the third issue cycle: two handshakes, no done
        send(IVEC_FMT_4X16, 4'd2, 4, 2, 2, 1'b0, 0, acc);
        sb_cycle = acc + 3;
        wait_cycle(acc + 3);
        chk("t5_valid_under_setback", {31'd0, issue_valid}, 32'd0);
        chk("t5_ready_under_setback", {31'd0, req_ready},   32'd0);
        send(IVEC_FMT_4X8, 4'd1, 2, 1, 2, 1'b1, 0, acc2);
        chk("t5_reaccept_cycle", acc2, acc + 4);
        drain("t5");
        sb_cycle = -100;

        // setback together with a request in IDLE: accepted one cycle later
        sbc = cyc + 1;
        sb_cycle = sbc;
        send(IVEC_FMT_2X4, 4'd1, 2, 1, 2, 1'b1, 0, acc);
        chk("t6_accept_after_setback", acc, sbc + 1);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
